// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and constants for the TMR prefetch-buffer recovery sequencer.
package cv32e40p_tmr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DETECT,
        ST_FLUSH,
        ST_VERIFY,
        ST_FATAL
    } tmr_rec_state_e;

    // Bit positions in the voter error vector
    localparam int ERR_FETCH_VALID = 0;
    localparam int ERR_FETCH_RDATA = 1;
    localparam int ERR_INSTR_REQ   = 2;
    localparam int ERR_INSTR_ADDR  = 3;
    localparam int ERR_BUSY        = 4;

    // Counter widths sized for the legal parameter ranges (15 / 255 / 7)
    localparam int RUN_W   = 4;
    localparam int QUIET_W = 8;
    localparam int RETRY_W = 3;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module cv32e40p_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cv32e40p_tmr_recovery_ctrl.sv
// Recovery sequencer for the triplicated prefetch buffer: stalls fetch, forces a refetch
// branch and verifies resync. Optional sticky error log under CV32E40P_TMR_ERR_STATS_EN.
module cv32e40p_tmr_recovery_ctrl
    import cv32e40p_tmr_pkg::*;
#(
    parameter int NSIG          = 5,
    parameter int ERR_THRESH    = 2,
    parameter int VERIFY_CYCLES = 8,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NSIG-1:0]  error_voter_i,
    input  logic             core_branch_i,
    input  logic [31:0]      core_branch_addr_i,
    input  logic [31:0]      resume_addr_i,
    input  logic             pf_fetch_valid_i,
    output logic             pf_branch_o,
    output logic [31:0]      pf_branch_addr_o,
    output logic             core_fetch_valid_o,
    output logic             recovering_o,
    output logic             fatal_o,
    output logic [CNT_W-1:0] recovery_cnt_o,
    output logic [NSIG-1:0]  err_log_o,
    input  logic             err_log_clr_i
);

    // Counters hold "events seen so far"; a hit means this cycle's event reaches the limit
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(ERR_THRESH - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(VERIFY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    tmr_rec_state_e r_state;
    logic           r_flush;
    logic           r_recovering;
    logic           r_fatal;

    logic               w_err_any;
    logic [RUN_W-1:0]   w_run;
    logic [QUIET_W-1:0] w_quiet;
    logic [RETRY_W-1:0] w_retry;
    logic               w_run_hit;
    logic               w_quiet_hit;
    logic               w_retry_hit;
    logic               w_run_inc;
    logic               w_verify_ok;
    logic               w_verify_bad;
    logic               w_retry_clr;
    logic               w_rcnt_inc;

    assign w_err_any   = |error_voter_i;
    assign w_run_hit   = (w_run == RUN_LAST);
    assign w_quiet_hit = (w_quiet == QUIET_LAST);
    assign w_retry_hit = (w_retry == RETRY_LAST);

    // A core branch in VERIFY is itself a flush, so it neither counts as clean nor as a failure
    assign w_run_inc    = w_err_any && ((r_state == ST_IDLE) ||
                                        ((r_state == ST_DETECT) && !core_branch_i));
    assign w_verify_ok  = (r_state == ST_VERIFY) && !core_branch_i && !w_err_any;
    assign w_verify_bad = (r_state == ST_VERIFY) && !core_branch_i && w_err_any;
    assign w_retry_clr  = (r_state == ST_IDLE);
    assign w_rcnt_inc   = w_verify_ok && w_quiet_hit;

    cv32e40p_sat_counter #(.WIDTH(RUN_W)) u_run_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_run_inc),
        .i_clr   (!w_run_inc),
        .o_count (w_run)
    );

    cv32e40p_sat_counter #(.WIDTH(QUIET_W)) u_quiet_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_verify_ok),
        .i_clr   (!w_verify_ok),
        .o_count (w_quiet)
    );

    cv32e40p_sat_counter #(.WIDTH(RETRY_W)) u_retry_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_verify_bad),
        .i_clr   (w_retry_clr),
        .o_count (w_retry)
    );

    cv32e40p_sat_counter #(.WIDTH(CNT_W)) u_recovery_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rcnt_inc),
        .i_clr   (1'b0),
        .o_count (recovery_cnt_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_flush      <= 1'b0;
            r_recovering <= 1'b0;
            r_fatal      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_err_any) begin
                        if (w_run_hit) begin
                            r_state      <= ST_FLUSH;
                            r_flush      <= 1'b1;
                            r_recovering <= 1'b1;
                        end else begin
                            r_state <= ST_DETECT;
                        end
                    end
                end
                ST_DETECT: begin
                    if (core_branch_i) begin
                        r_state      <= ST_VERIFY;
                        r_recovering <= 1'b1;
                    end else if (!w_err_any) begin
                        r_state <= ST_IDLE;
                    end else if (w_run_hit) begin
                        r_state      <= ST_FLUSH;
                        r_flush      <= 1'b1;
                        r_recovering <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_VERIFY;
                    r_flush <= 1'b0;
                end
                ST_VERIFY: begin
                    if (core_branch_i) begin
                        r_state <= ST_VERIFY;
                    end else if (w_err_any) begin
                        if (w_retry_hit) begin
                            r_state      <= ST_FATAL;
                            r_recovering <= 1'b0;
                            r_fatal      <= 1'b1;
                        end else begin
                            r_state <= ST_FLUSH;
                            r_flush <= 1'b1;
                        end
                    end else if (w_quiet_hit) begin
                        r_state      <= ST_IDLE;
                        r_recovering <= 1'b0;
                    end
                end
                ST_FATAL: begin
                    r_state <= ST_FATAL;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_flush      <= 1'b0;
                    r_recovering <= 1'b0;
                    r_fatal      <= 1'b0;
                end
            endcase
        end
    end

    // A core branch during FLUSH already refetches everything, so its target wins
    assign pf_branch_o        = core_branch_i | r_flush;
    assign pf_branch_addr_o   = (r_flush && !core_branch_i) ? resume_addr_i : core_branch_addr_i;
    assign core_fetch_valid_o = pf_fetch_valid_i & ~r_recovering;
    assign recovering_o       = r_recovering;
    assign fatal_o            = r_fatal;

`ifdef CV32E40P_TMR_ERR_STATS_EN
    logic [NSIG-1:0] r_err_log;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_log <= '0;
        end else if (err_log_clr_i) begin
            r_err_log <= '0;
        end else begin
            r_err_log <= r_err_log | error_voter_i;
        end
    end

    assign err_log_o = r_err_log;
`else
    logic w_unused_clr;
    assign w_unused_clr = err_log_clr_i;
    assign err_log_o    = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_recovery_ctrl.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_cv32e40p_tmr_recovery_ctrl;

    localparam int ET = 2;
    localparam int VC = 8;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  error_voter_i = '0;
    logic        core_branch_i = 1'b0;
    logic [31:0] core_branch_addr_i = '0;
    logic [31:0] resume_addr_i = '0;
    logic        pf_fetch_valid_i = 1'b0;
    logic        pf_branch_o;
    logic [31:0] pf_branch_addr_o;
    logic        core_fetch_valid_o;
    logic        recovering_o;
    logic        fatal_o;
    logic [7:0]  recovery_cnt_o;
    logic [4:0]  err_log_o;
    logic        err_log_clr_i = 1'b0;

    cv32e40p_tmr_recovery_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .error_voter_i      (error_voter_i),
        .core_branch_i      (core_branch_i),
        .core_branch_addr_i (core_branch_addr_i),
        .resume_addr_i      (resume_addr_i),
        .pf_fetch_valid_i   (pf_fetch_valid_i),
        .pf_branch_o        (pf_branch_o),
        .pf_branch_addr_o   (pf_branch_addr_o),
        .core_fetch_valid_o (core_fetch_valid_o),
        .recovering_o       (recovering_o),
        .fatal_o            (fatal_o),
        .recovery_cnt_o     (recovery_cnt_o),
        .err_log_o          (err_log_o),
        .err_log_clr_i      (err_log_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic [31:0] addr;
        logic        cfv;
        logic        rec;
        logic        fat;
        logic [7:0]  cnt;
        logic [4:0]  log;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   flush_seen = 0;

    // Reference model: an error streak, a pending flush, a clean-cycle tally, a failure tally
    int         m_streak, m_clean, m_fails, m_rec;
    bit         m_flush, m_check, m_dead;
    logic [4:0] m_log;

    logic        s_br, s_cfv, s_rec;
    logic [31:0] s_addr;
    logic [4:0]  s_log;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0; m_clean = 0; m_fails = 0; m_rec = 0;
        m_flush = 0; m_check = 0; m_dead = 0; m_log = '0;
    endtask

    task automatic model_step(input logic [4:0] e, input logic b, input logic cl);
        bit err;
        err = (e != 0);
        m_log = cl ? 5'd0 : (m_log | e);
        if (m_dead) begin
        end else if (m_flush) begin
            m_flush = 0; m_check = 1; m_clean = 0;
        end else if (m_check) begin
            if (b) m_clean = 0;
            else if (!err) begin
                m_clean++;
                if (m_clean == VC) begin
                    m_check = 0; m_fails = 0;
                    if (m_rec < 255) m_rec++;
                end
            end else begin
                m_fails++; m_check = 0;
                if (m_fails == MR) m_dead = 1;
                else m_flush = 1;
            end
        end else if (m_streak > 0 && b) begin
            m_check = 1; m_clean = 0; m_streak = 0;
        end else if (err) begin
            m_streak++;
            if (m_streak == ET) begin
                m_flush = 1; m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
    endtask

    // Called just after a rising edge; returns just after the next rising edge
    task automatic drive(input logic [4:0] e, input logic b, input logic [31:0] ba,
                         input logic [31:0] ra, input logic pv, input logic cl);
        exp_t x;
        error_voter_i = e; core_branch_i = b; core_branch_addr_i = ba;
        resume_addr_i = ra; pf_fetch_valid_i = pv; err_log_clr_i = cl;
        x.rec  = m_flush || m_check;
        x.fat  = m_dead;
        x.br   = b || m_flush;
        x.addr = (m_flush && !b) ? ra : ba;
        x.cfv  = pv && !x.rec;
        x.cnt  = 8'(m_rec);
`ifdef CV32E40P_TMR_ERR_STATS_EN
        x.log  = m_log;
`else
        x.log  = '0;
`endif
        exp_q.push_back(x);
        @(negedge clk);
        s_br = pf_branch_o; s_addr = pf_branch_addr_o; s_cfv = core_fetch_valid_o;
        s_rec = recovering_o; s_log = err_log_o;
        @(posedge clk);
        model_step(e, b, cl);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset; outputs are checked before any clock edge arrives
    task automatic do_reset();
        rst_n = 1'b0;
        error_voter_i = '0; core_branch_i = 1'b0; core_branch_addr_i = '0;
        resume_addr_i = '0; pf_fetch_valid_i = 1'b0; err_log_clr_i = 1'b0;
        #1;
        check("rst_pf_branch", 32'(pf_branch_o), 32'd0);
        check("rst_recovering", 32'(recovering_o), 32'd0);
        check("rst_fatal", 32'(fatal_o), 32'd0);
        check("rst_cnt", 32'(recovery_cnt_o), 32'd0);
        check("rst_log", 32'(err_log_o), 32'd0);
        check("rst_cfv", 32'(core_fetch_valid_o), 32'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check("pf_branch", 32'(pf_branch_o), 32'(x.br));
            if (x.br) check("pf_branch_addr", pf_branch_addr_o, x.addr);
            check("core_fetch_valid", 32'(core_fetch_valid_o), 32'(x.cfv));
            check("recovering", 32'(recovering_o), 32'(x.rec));
            check("fatal", 32'(fatal_o), 32'(x.fat));
            check("recovery_cnt", 32'(recovery_cnt_o), 32'(x.cnt));
            check("err_log", 32'(err_log_o), 32'(x.log));
            if (pf_branch_o && !core_branch_i) flush_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int burst;
        int pe;
        logic [4:0] e;
        model_reset();
        do_reset();

        // Transient single-cycle error
        flush_seen = 0;
        drive(5'b00010, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle_cycles(5);
        check("transient_flushes", 32'(flush_seen), 32'd0);
        check("transient_cnt", 32'(recovery_cnt_o), 32'd0);

        // Persistent-for-threshold error, then clean resync
        drive(5'b01000, 1'b0, 32'h0, 32'h1004, 1'b1, 1'b0);
        drive(5'b01000, 1'b0, 32'h0, 32'h1004, 1'b1, 1'b0);
        drive(5'b00000, 1'b0, 32'h0, 32'h1004, 1'b1, 1'b0);
        check("flush_pulse", 32'(s_br), 32'd1);
        check("flush_addr", s_addr, 32'h1004);
        check("flush_cfv", 32'(s_cfv), 32'd0);
        idle_cycles(8);
        idle_cycles(1);
        check("resync_cnt", 32'(recovery_cnt_o), 32'd1);
        check("resync_rec", 32'(s_rec), 32'd0);

        // Error never clears -> three flushes then fatal passthrough
        do_reset();
        flush_seen = 0;
        for (int i = 0; i < 12; i++) drive(5'b00100, 1'b0, 32'h0, 32'h40, 1'b1, 1'b0);
        check("retry_flushes", 32'(flush_seen), 32'(MR));
        check("fatal_set", 32'(fatal_o), 32'd1);
        drive(5'b00000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("fatal_cfv_pass", 32'(s_cfv), 32'd1);
        drive(5'b00000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("fatal_cfv_low", 32'(s_cfv), 32'd0);

        // Core branch coinciding with the flush
        do_reset();
        drive(5'b00001, 1'b0, 32'h0, 32'h1004, 1'b1, 1'b0);
        drive(5'b00001, 1'b0, 32'h0, 32'h1004, 1'b1, 1'b0);
        drive(5'b00000, 1'b1, 32'h2000, 32'h1004, 1'b1, 1'b0);
        check("coflush_addr", s_addr, 32'h2000);
        drive(5'b00000, 1'b0, 32'h0, 32'h1004, 1'b1, 1'b0);
        check("coflush_single", 32'(s_br), 32'd0);
        check("coflush_verify", 32'(s_rec), 32'd1);
        idle_cycles(10);

        // Reset while verifying; the earlier recovery count is lost
        drive(5'b00001, 1'b0, 32'h0, 32'h88, 1'b1, 1'b0);
        drive(5'b00001, 1'b0, 32'h0, 32'h88, 1'b1, 1'b0);
        drive(5'b00000, 1'b0, 32'h0, 32'h88, 1'b1, 1'b0);
        drive(5'b00000, 1'b0, 32'h0, 32'h88, 1'b1, 1'b0);
        do_reset();
        flush_seen = 0;
        idle_cycles(10);
        check("post_reset_flushes", 32'(flush_seen), 32'd0);

`ifdef CV32E40P_TMR_ERR_STATS_EN
        do_reset();
        drive(5'b00001, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(5'b10000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(5'b00000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("log_bits", 32'(s_log), 32'h11);
        drive(5'b00100, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        drive(5'b00000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("log_clr_wins", 32'(s_log), 32'h0);
`endif

        // Randomized segments with bursty errors and occasional core branches
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            pe = (seg % 3 == 0) ? 6 : ((seg % 3 == 1) ? 3 : 12);
            burst = 0;
            for (int c = 0; c < 250; c++) begin
                if (burst == 0 && $urandom_range(pe * 2) == 0) burst = $urandom_range(6, 1);
                if (burst > 0 || $urandom_range(pe) == 0) e = 5'($urandom_range(31, 1));
                else e = 5'd0;
                if (burst > 0) burst--;
                drive(e, ($urandom_range(15) == 0), $urandom, $urandom,
                      1'($urandom_range(1)), ($urandom_range(7) == 0));
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
